// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the alu_sequencer control unit: state encoding,
// ALU opcode values, IR field positions and register-select decode helpers.
package alu_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_t;

   // Execute-phase shape of an instruction
   typedef enum logic [1:0] {
      CLS_BINARY     = 2'd0,
      CLS_UNARY      = 2'd1,
      CLS_TWO_RESULT = 2'd2,
      CLS_ILLEGAL    = 2'd3
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int RA_MSB     = 26;
   localparam int RA_LSB     = 23;
   localparam int RB_MSB     = 22;
   localparam int RB_LSB     = 19;
   localparam int RC_MSB     = 18;
   localparam int RC_LSB     = 15;

   // 4-bit register index to one-hot R0..R15 select
   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      onehot16 = 16'h0001 << idx;
   endfunction

   // Map an opcode to the execute sequence it needs
   function automatic op_class_t classify_op(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:         classify_op = CLS_BINARY;
         OP_NEG, OP_NOT:                          classify_op = CLS_UNARY;
         OP_MUL, OP_DIV:                          classify_op = CLS_TWO_RESULT;
         default:                                 classify_op = CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/alu_sequencer_reg_select_decode.sv
// reg_select_decode: turns a register index plus enable into a one-hot
// R0..R15 select; zero when disabled so the bus never sees two drivers.
module reg_select_decode
   import alu_sequencer_pkg::*;
(
   input  logic [3:0]  index,
   input  logic        enable,
   output logic [15:0] select
);

   // One select line when enabled, none otherwise
   always_comb begin
      if (enable) begin
         select = onehot16(index);
      end else begin
         select = 16'h0000;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired fetch/execute control for register-to-register
// ALU instructions. Strobes are decoded from the state register and ir only.
// Optional build macro SINGLE_STEP_EN adds a step input that gates each
// instruction start and forces a return to IDLE after every instruction.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic        mem_rdy,
   input  logic [31:0] ir,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        incPC,
   output logic        MARin,
   output logic        read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        ZLowOut,
   output logic        ZHighOut,
   output logic        LOin,
   output logic        HIin,
   output logic [4:0]  opcode,
   output logic        done,
   output logic        illegal,
   output logic [3:0]  state
);

   state_t     state_r;
   logic       illegal_r;

   logic [4:0] op_s;
   logic [3:0] ra_s;
   logic [3:0] rb_s;
   logic [3:0] rc_s;
   op_class_t  op_class_s;
   logic       start_s;
   state_t     after_done_s;

   logic       rin_en_s;
   logic [3:0] rin_idx_s;
   logic       rout_en_s;
   logic [3:0] rout_idx_s;
   logic       unused_ir_s;

   assign op_s        = ir[OPCODE_MSB:OPCODE_LSB];
   assign ra_s        = ir[RA_MSB:RA_LSB];
   assign rb_s        = ir[RB_MSB:RB_LSB];
   assign rc_s        = ir[RC_MSB:RC_LSB];
   assign op_class_s  = classify_op(op_s);
   assign unused_ir_s = ^ir[RC_LSB-1:0];

`ifdef SINGLE_STEP_EN
   assign start_s      = run & step;
   assign after_done_s = ST_IDLE;
`else
   assign start_s      = run;
   assign after_done_s = run ? ST_T0 : ST_IDLE;
`endif

   // State sequencing and sticky illegal-opcode flag; clear dominates everything
   always_ff @(posedge clock) begin
      if (clear) begin
         state_r   <= ST_IDLE;
         illegal_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r <= ST_T0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_T0: state_r <= ST_T1;
            ST_T1: begin
               if (mem_rdy) begin
                  state_r <= ST_T2;
               end else begin
                  state_r <= ST_T1;
               end
            end
            ST_T2: state_r <= ST_T3;
            ST_T3: begin
               if (op_class_s == CLS_ILLEGAL) begin
                  state_r   <= ST_HALT;
                  illegal_r <= 1'b1;
               end else begin
                  state_r <= ST_T4;
               end
            end
            ST_T4: state_r <= ST_T5;
            ST_T5: begin
               if (op_class_s == CLS_TWO_RESULT) begin
                  state_r <= ST_T6;
               end else begin
                  state_r <= after_done_s;
               end
            end
            ST_T6:   state_r <= after_done_s;
            ST_HALT: state_r <= ST_HALT;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Strobe decode from the current state and the instruction fields
   always_comb begin
      PCout      = 1'b0;
      incPC      = 1'b0;
      MARin      = 1'b0;
      read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      Zin        = 1'b0;
      ZLowOut    = 1'b0;
      ZHighOut   = 1'b0;
      LOin       = 1'b0;
      HIin       = 1'b0;
      opcode     = 5'd0;
      done       = 1'b0;
      rin_en_s   = 1'b0;
      rin_idx_s  = 4'd0;
      rout_en_s  = 1'b0;
      rout_idx_s = 4'd0;
      case (state_r)
         ST_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            incPC = 1'b1;
         end
         ST_T1: begin
            read  = 1'b1;
            MDRin = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            case (op_class_s)
               CLS_BINARY: begin
                  rout_en_s  = 1'b1;
                  rout_idx_s = rb_s;
                  Yin        = 1'b1;
               end
               CLS_TWO_RESULT: begin
                  rout_en_s  = 1'b1;
                  rout_idx_s = ra_s;
                  Yin        = 1'b1;
               end
               default: begin
                  rout_en_s = 1'b0;
               end
            endcase
         end
         ST_T4: begin
            case (op_class_s)
               CLS_BINARY: begin
                  rout_en_s  = 1'b1;
                  rout_idx_s = rc_s;
                  opcode     = op_s;
                  Zin        = 1'b1;
               end
               CLS_UNARY, CLS_TWO_RESULT: begin
                  rout_en_s  = 1'b1;
                  rout_idx_s = rb_s;
                  opcode     = op_s;
                  Zin        = 1'b1;
               end
               default: begin
                  rout_en_s = 1'b0;
               end
            endcase
         end
         ST_T5: begin
            case (op_class_s)
               CLS_BINARY, CLS_UNARY: begin
                  ZLowOut   = 1'b1;
                  rin_en_s  = 1'b1;
                  rin_idx_s = ra_s;
                  done      = 1'b1;
               end
               CLS_TWO_RESULT: begin
                  ZLowOut = 1'b1;
                  LOin    = 1'b1;
               end
               default: begin
                  rin_en_s = 1'b0;
               end
            endcase
         end
         ST_T6: begin
            ZHighOut = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

   reg_select_decode u_rin_decode (
      .index  (rin_idx_s),
      .enable (rin_en_s),
      .select (Rin)
   );

   reg_select_decode u_rout_decode (
      .index  (rout_idx_s),
      .enable (rout_en_s),
      .select (Rout)
   );

   assign illegal = illegal_r;
   assign state   = state_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios followed by
// randomized instructions, each cycle compared against an expected strobe
// word built from the instruction-level timing rules.
module tb_alu_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        run;
   logic        mem_rdy;
   logic [31:0] ir;
`ifdef SINGLE_STEP_EN
   logic        step;
`endif
   logic [15:0] Rin, Rout;
   logic        PCout, incPC, MARin, read, MDRin, MDRout, IRin;
   logic        Yin, Zin, ZLowOut, ZHighOut, LOin, HIin;
   logic [4:0]  opcode;
   logic        done, illegal;
   logic [3:0]  state;

   int vectors     = 0;
   int miscompares = 0;

   localparam int B_PCOUT = 0, B_INCPC = 1, B_MARIN = 2, B_READ = 3, B_MDRIN = 4;
   localparam int B_MDROUT = 5, B_IRIN = 6, B_YIN = 7, B_ZIN = 8, B_ZLOW = 9;
   localparam int B_ZHIGH = 10, B_LOIN = 11, B_HIIN = 12;

   logic [12:0] strobes;
   logic [51:0] obs;
   assign strobes = {HIin, LOin, ZHighOut, ZLowOut, Zin, Yin, IRin, MDRout,
                     MDRin, read, MARin, incPC, PCout};
   assign obs     = {Rin, Rout, strobes, opcode, done, illegal};

   logic [4:0] legal_ops [0:12] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                    5'd10, 5'd11, 5'd14, 5'd15, 5'd16, 5'd17};

   always #5 clock = ~clock;

   alu_sequencer dut (
      .clock    (clock),
      .clear    (clear),
      .run      (run),
`ifdef SINGLE_STEP_EN
      .step     (step),
`endif
      .mem_rdy  (mem_rdy),
      .ir       (ir),
      .Rin      (Rin),
      .Rout     (Rout),
      .PCout    (PCout),
      .incPC    (incPC),
      .MARin    (MARin),
      .read     (read),
      .MDRin    (MDRin),
      .MDRout   (MDRout),
      .IRin     (IRin),
      .Yin      (Yin),
      .Zin      (Zin),
      .ZLowOut  (ZLowOut),
      .ZHighOut (ZHighOut),
      .LOin     (LOin),
      .HIin     (HIin),
      .opcode   (opcode),
      .done     (done),
      .illegal  (illegal),
      .state    (state)
   );

   function automatic logic [12:0] sb(input int b);
      sb = 13'd1 << b;
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] r);
      oh = 16'd1 << r;
   endfunction

   function automatic logic [51:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [12:0] s, input logic [4:0] op,
                                      input logic dn, input logic il);
      mk = {rin, rout, s, op, dn, il};
   endfunction

   // 0 = binary, 1 = unary, 2 = mul/div, 3 = unsupported
   function automatic int kind(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd11) return 0;
      else if (op == 5'd16 || op == 5'd17) return 1;
      else if (op == 5'd14 || op == 5'd15) return 2;
      else return 3;
   endfunction

   function automatic logic single_step_build();
`ifdef SINGLE_STEP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_step(input logic v);
`ifdef SINGLE_STEP_EN
      step = v;
`else
      if (v) begin end
`endif
   endtask

   task automatic tick(input logic [51:0] exp, input string tag);
      @(negedge clock);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      @(posedge clock);
      #1;
   endtask

   // Runs one instruction starting with the DUT in T0
   task automatic do_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int waits, input logic run_end,
                           input logic clear_t4, input string tag, output logic went_idle);
      int k;
      k  = kind(op);
      ir = {op, ra, rb, rc, 15'($urandom)};
      run = 1'($urandom_range(0, 1));
      set_step(1'($urandom_range(0, 1)));
      mem_rdy = 1'($urandom_range(0, 1));
      tick(mk(16'd0, 16'd0, sb(B_PCOUT) | sb(B_INCPC) | sb(B_MARIN), 5'd0, 1'b0, 1'b0), {tag, "_t0"});
      for (int i = 0; i < waits; i++) begin
         mem_rdy = 1'b0;
         tick(mk(16'd0, 16'd0, sb(B_READ) | sb(B_MDRIN), 5'd0, 1'b0, 1'b0), {tag, "_t1wait"});
      end
      mem_rdy = 1'b1;
      tick(mk(16'd0, 16'd0, sb(B_READ) | sb(B_MDRIN), 5'd0, 1'b0, 1'b0), {tag, "_t1"});
      mem_rdy = 1'($urandom_range(0, 1));
      tick(mk(16'd0, 16'd0, sb(B_MDROUT) | sb(B_IRIN), 5'd0, 1'b0, 1'b0), {tag, "_t2"});
      went_idle = 1'b1;
      case (k)
         0: begin
            tick(mk(16'd0, oh(rb), sb(B_YIN), 5'd0, 1'b0, 1'b0), {tag, "_t3"});
            if (clear_t4) begin
               clear = 1'b1;
               run   = 1'b1;
               tick(mk(16'd0, oh(rc), sb(B_ZIN), op, 1'b0, 1'b0), {tag, "_t4"});
               clear = 1'b0;
               run   = 1'b0;
               return;
            end
            tick(mk(16'd0, oh(rc), sb(B_ZIN), op, 1'b0, 1'b0), {tag, "_t4"});
            run = run_end;
            tick(mk(oh(ra), 16'd0, sb(B_ZLOW), 5'd0, 1'b1, 1'b0), {tag, "_t5"});
         end
         1: begin
            tick(mk(16'd0, 16'd0, 13'd0, 5'd0, 1'b0, 1'b0), {tag, "_t3"});
            tick(mk(16'd0, oh(rb), sb(B_ZIN), op, 1'b0, 1'b0), {tag, "_t4"});
            run = run_end;
            tick(mk(oh(ra), 16'd0, sb(B_ZLOW), 5'd0, 1'b1, 1'b0), {tag, "_t5"});
         end
         2: begin
            tick(mk(16'd0, oh(ra), sb(B_YIN), 5'd0, 1'b0, 1'b0), {tag, "_t3"});
            tick(mk(16'd0, oh(rb), sb(B_ZIN), op, 1'b0, 1'b0), {tag, "_t4"});
            tick(mk(16'd0, 16'd0, sb(B_ZLOW) | sb(B_LOIN), 5'd0, 1'b0, 1'b0), {tag, "_t5"});
            run = run_end;
            tick(mk(16'd0, 16'd0, sb(B_ZHIGH) | sb(B_HIIN), 5'd0, 1'b1, 1'b0), {tag, "_t6"});
         end
         default: begin
            tick(mk(16'd0, 16'd0, 13'd0, 5'd0, 1'b0, 1'b0), {tag, "_t3"});
            return;
         end
      endcase
      went_idle = single_step_build() | ~run_end;
   endtask

   initial begin
      logic       idle;
      logic [4:0] op;
      logic [51:0] zero;
      logic [51:0] halted;
      zero    = mk(16'd0, 16'd0, 13'd0, 5'd0, 1'b0, 1'b0);
      halted  = mk(16'd0, 16'd0, 13'd0, 5'd0, 1'b0, 1'b1);
      clear   = 1'b1;
      run     = 1'b0;
      mem_rdy = 1'b1;
      ir      = 32'd0;
      set_step(1'b0);
      @(posedge clock);
      #1;
      tick(zero, "reset_idle");
      clear = 1'b0;
      tick(zero, "idle_hold");

      // add R4,R3,R7 back-to-back into div R2,R6
      run = 1'b1;
      set_step(1'b1);
      tick(zero, "start");
      do_instr(5'b00011, 4'd4, 4'd3, 4'd7, 0, 1'b1, 1'b0, "add", idle);
      if (idle) begin
         run = 1'b1;
         set_step(1'b1);
         tick(zero, "restart1");
      end
      do_instr(5'b01111, 4'd2, 4'd6, 4'd0, 0, 1'b1, 1'b0, "div", idle);
      if (idle) begin
         run = 1'b1;
         set_step(1'b1);
         tick(zero, "restart2");
      end

      // fetch wait states, then run dropped so the sequencer parks in IDLE
      do_instr(5'b00011, 4'd1, 4'd5, 4'd9, 3, 1'b0, 1'b0, "add_wait", idle);
      run = 1'b0;
      tick(zero, "idle_after_done");
`ifdef SINGLE_STEP_EN
      run = 1'b1;
      set_step(1'b0);
      tick(zero, "nostep1");
      tick(zero, "nostep2");
      tick(zero, "nostep3");
`endif

      // clear during T4 aborts the add even with run high
      run = 1'b1;
      set_step(1'b1);
      tick(zero, "start_clr");
      do_instr(5'b00011, 4'd4, 4'd3, 4'd7, 0, 1'b1, 1'b1, "add_clr", idle);
      tick(zero, "clr_idle");
      tick(zero, "clr_idle2");

      // unsupported opcode halts and latches illegal until clear
      run = 1'b1;
      set_step(1'b1);
      tick(zero, "start_ill");
      do_instr(5'b11111, 4'd0, 4'd0, 4'd0, 0, 1'b1, 1'b0, "ill", idle);
      for (int i = 0; i < 4; i++) begin
         run = 1'($urandom_range(0, 1));
         set_step(1'($urandom_range(0, 1)));
         mem_rdy = 1'($urandom_range(0, 1));
         tick(halted, "halt");
      end
      clear = 1'b1;
      tick(halted, "halt_clear");
      clear = 1'b0;
      run   = 1'b0;
      tick(zero, "post_clear");

      // randomized legal instructions
      idle = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if (idle) begin
            run = 1'b1;
            set_step(1'b1);
            tick(zero, "rnd_start");
         end
         op = legal_ops[$urandom_range(0, 12)];
         do_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", n), idle);
         if (idle && ($urandom_range(0, 1) == 1)) begin
            run = 1'b0;
            tick(zero, "rnd_idle");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Hardwired control unit that sequences the register-file/ALU datapath through instruction fetch (T0–T2) and execute (T3–T6) for register-to-register ALU instructions. It decodes the instruction held in IR and produces every bus-driver, register-load and ALU-opcode strobe the datapath consumes, one T-state per clock. It sits beside the datapath and replaces hand-driven strobes from benches.

## Interface
- No parameters.
- clock  in  1  system clock, all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- run  in  1  level; high allows instructions to start
- mem_rdy  in  1  memory read data valid (fetch wait-state handshake)
- ir  in  32  IR contents from datapath: opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
- Rin / Rout  out  16  one-hot register load / bus-drive selects (R0..R15)
- PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, LOin, HIin  out  1  datapath strobes
- opcode  out  5  ALU operation, valid in T4 only, else 0
- done  out  1  one-cycle pulse in last execute state
- illegal  out  1  sticky; set on unsupported opcode
- state  out  4  current state encoding (debug)

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a pure decode of state register and ir; no other input reaches outputs combinationally.
- IDLE → T0 when run=1; otherwise stay. All strobes 0.
- T0: PCout, MARin, incPC. T1: read, MDRin; stay in T1 while mem_rdy=0, advance when mem_rdy=1. T2: MDRout, IRin. IR valid from T3.
- Binary ops (add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011): T3 Rout[rb], Yin; T4 Rout[rc], opcode=ir[31:27], Zin; T5 ZLowOut, Rin[ra], done.
- Unary ops (neg 10000, not 10001): T3 no strobes; T4 Rout[rb], opcode, Zin; T5 ZLowOut, Rin[ra], done.
- Two-result ops (mul 01110, div 01111): T3 Rout[ra], Yin; T4 Rout[rb], opcode, Zin; T5 ZLowOut, LOin; T6 ZHighOut, HIin, done.
- Any other opcode at T3: → HALT, set illegal, no strobes. HALT exits only via clear.
- After done state: → T0 if run=1, else IDLE. run is sampled only in IDLE and at the done state; dropping run mid-instruction finishes the instruction.
- Rin/Rout always one-hot or zero; never more than one bus driver active per cycle.

## Timing
- Reset: state=IDLE, illegal=0, all outputs 0 in the cycle after clear sampled high; clear mid-instruction aborts immediately.
- Fetch latency 3 cycles + mem_rdy wait cycles. Instruction latency from T0: 6 cycles (binary/unary), 7 (mul/div), zero wait states.
- Back-to-back: done state followed directly by T0, no bubble.
- clear and run both high: clear wins.

## Configuration
- SINGLE_STEP_EN defined: extra input step (1 bit); IDLE → T0 requires run=1 and step=1 in same cycle; after done state always → IDLE. Undefined: no step port; behaviour as above.

## Structure
- Shared package: state enum, opcode constants, IR field bit positions, one-hot decode function 4→16.
- One sub-module: reg_select_decode (4-bit index + enable → 16-bit one-hot), instantiated for Rin and Rout.

## Test plan
- add R4,R3,R7 (ir opcode 00011, ra=4, rb=3, rc=7), run=1, mem_rdy=1 → T3 Rout=0x0008 Yin; T4 Rout=0x0080 opcode=00011 Zin; T5 Rin=0x0010 ZLowOut done; next cycle T0.
- div R2,R6 (01111, ra=2, rb=6) → T3 Rout=0x0004, T4 Rout=0x0040 opcode=01111, T5 LOin, T6 HIin + done; 7 cycles total.
- mem_rdy low 3 cycles in T1 → read/MDRin held 4 cycles, IRin one cycle later, no other strobe.
- opcode 11111 → HALT after T3, illegal=1 persistent, run toggling ignored; clear → IDLE, illegal=0.
- clear asserted in T4 → next cycle IDLE, all outputs 0, Zin never repeats.
- run dropped during T4 of add → instruction completes, done pulses, then IDLE; with SINGLE_STEP_EN, run=1 and no step → remains IDLE.
